// File: rtl/lsu_mem_stage_if.sv
// Request/response bundle between the pipeline registers and the memory-stage LSU.
// dbg_state mirrors the LSU FSM so checkers can bind to it without reaching inside.
interface lsu_mem_stage_if;
  logic        i_mem_rden;
  logic        i_mem_wren;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic [2:0]  i_ld_rewrite;
  logic [1:0]  i_st_rewrite;
  logic [31:0] o_ld_data;
  logic        o_ld_vld;
  logic        o_stall;
  logic        o_err;
  logic        dbg_state;

  // Handshake: a request is presented when i_mem_rden or i_mem_wren is high and is
  // accepted in any cycle where o_stall is low; while o_stall is high the upstream
  // holds every request field unchanged, and o_ld_vld/o_err are single-cycle pulses.
  modport master (
    output i_mem_rden, i_mem_wren, i_addr, i_st_data, i_ld_rewrite, i_st_rewrite,
    input  o_ld_data, o_ld_vld, o_stall, o_err, dbg_state
  );

  modport slave (
    input  i_mem_rden, i_mem_wren, i_addr, i_st_data, i_ld_rewrite, i_st_rewrite,
    output o_ld_data, o_ld_vld, o_stall, o_err, dbg_state
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: byte/half/word loads and stores on a word RAM, with a
// two-cycle sequence for accesses that straddle a word boundary.
module lsu_mem_stage #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic            i_clk,
  input logic            i_reset,
  lsu_mem_stage_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx, idx_nxt, acc_idx;
  logic [1:0]    lane;
  logic [2:0]    size;
  logic [3:0]    size_mask;
  logic          ld_ok, st_ok, illegal, split;
  logic [7:0]    be8;
  logic [63:0]   wdata64, raw64, shifted;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data, rd_word, lo_q, raw, ext;
  logic          wr_en;
  logic          unused_bits;

  assign idx     = bus.i_addr[AW+1:2];
  assign idx_nxt = idx + AW'(1);
  assign lane    = bus.i_addr[1:0];

  always_comb begin
    size = 3'd1;
    if (bus.i_mem_rden) begin
      case (bus.i_ld_rewrite)
        3'd1, 3'd4: size = 3'd2;
        3'd2:       size = 3'd4;
        default:    size = 3'd1;
      endcase
    end else begin
      case (bus.i_st_rewrite)
        2'd1:    size = 3'd2;
        2'd2:    size = 3'd4;
        default: size = 3'd1;
      endcase
    end
  end

  assign size_mask = (size == 3'd4) ? 4'hF : (size == 3'd2) ? 4'h3 : 4'h1;

  assign ld_ok   = bus.i_mem_rden && !bus.i_mem_wren && (bus.i_ld_rewrite < 3'd5);
  assign st_ok   = bus.i_mem_wren && !bus.i_mem_rden && (bus.i_st_rewrite != 2'd3);
  assign illegal = (bus.i_mem_rden || bus.i_mem_wren) && !ld_ok && !st_ok;
  assign split   = ({1'b0, lane} + size) > 3'd4;

  assign bus.o_stall   = (state == IDLE) && (ld_ok || st_ok) && split;
  assign bus.dbg_state = state;

  // The first half of a split always touches idx; the second half touches idx+1.
  assign acc_idx = (state == SECOND) ? idx_nxt : idx;

  assign be8     = {4'b0000, size_mask} << lane;
  assign wdata64 = {32'h0, bus.i_st_data} << {lane, 3'b000};
  assign wr_be   = (state == SECOND) ? be8[7:4] : be8[3:0];
  assign wr_data = (state == SECOND) ? wdata64[63:32] : wdata64[31:0];
  // Reset gates the write so an aborted split never commits its second word.
  assign wr_en   = st_ok && !i_reset;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) mem[acc_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  assign rd_word = mem[acc_idx];
  assign raw64   = (state == SECOND) ? {rd_word, lo_q} : {32'h0, rd_word};
  assign shifted = raw64 >> {lane, 3'b000};
  assign raw     = shifted[31:0];

  always_comb begin
    ext = raw;
    case (bus.i_ld_rewrite)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd3:    ext = {24'h0, raw[7:0]};
      3'd4:    ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      lo_q          <= 32'h0;
      bus.o_ld_data <= 32'h0;
      bus.o_ld_vld  <= 1'b0;
      bus.o_err     <= 1'b0;
    end else if (state == IDLE) begin
      bus.o_err    <= illegal;
      bus.o_ld_vld <= ld_ok && !split;
      if (ld_ok && !split) bus.o_ld_data <= ext;
      if ((ld_ok || st_ok) && split) begin
        state <= SECOND;
        lo_q  <= rd_word;
      end
    end else begin
      state        <= IDLE;
      bus.o_err    <= 1'b0;
      bus.o_ld_vld <= ld_ok;
      if (ld_ok) bus.o_ld_data <= ext;
    end
  end

  assign unused_bits = ^{bus.i_addr[31:AW+2], shifted[63:32]};

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: expected load data goes into a queue when a
// load is issued and a negedge monitor pops it whenever o_ld_vld is seen.
module tb_lsu_mem_stage;
  localparam int DEPTH = 1024;

  logic i_clk = 1'b0;
  logic i_reset;
  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge i_clk) begin
    if (!i_reset && bus.o_ld_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ld_vld actual=0x%08h expected=none", bus.o_ld_data);
      end else begin
        check("ld_data", bus.o_ld_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks; each starts and ends at posedge+1
  task automatic idle_inputs();
    bus.i_mem_rden = 1'b0;
    bus.i_mem_wren = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] ldc,
                       input logic [1:0] stc, input int exp_stall);
    int n;
    bus.i_mem_rden   = rd;
    bus.i_mem_wren   = wr;
    bus.i_addr       = addr;
    bus.i_st_data    = data;
    bus.i_ld_rewrite = ldc;
    bus.i_st_rewrite = stc;
    n = 0;
    @(negedge i_clk);
    while (bus.o_stall === 1'b1 && n < 4) begin
      n++;
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check($sformatf("stall_cycles@%08h", addr), 32'(n), 32'(exp_stall));
    @(posedge i_clk);
    #1;
    idle_inputs();
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] code, input int stalls);
    issue(1'b0, 1'b1, addr, data, 3'd5, code, stalls);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [2:0] code,
                    input logic [31:0] exp, input int stalls);
    exp_q.push_back(exp);
    issue(1'b1, 1'b0, addr, 32'h0, code, 2'd3, stalls);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [2:0] ldc, input logic [1:0] stc);
    issue(rd, wr, addr, 32'h5A5A5A5A, ldc, stc, 0);
    @(negedge i_clk);
    check("err_pulse", 32'(bus.o_err), 32'd1);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.i_addr = 32'h0;
    bus.i_st_data = 32'h0;
    bus.i_ld_rewrite = 3'd5;
    bus.i_st_rewrite = 2'd3;
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ld_data", bus.o_ld_data, 32'h0);
    check("rst_ld_vld", 32'(bus.o_ld_vld), 32'h0);
    check("rst_err", 32'(bus.o_err), 32'h0);
    check("rst_stall", 32'(bus.o_stall), 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'h0);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // aligned word, read-after-write
    st(32'h10, 32'hDEADBEEF, 2'd2, 0);
    ld(32'h10, 3'd2, 32'hDEADBEEF, 0);

    // byte store into the top lane, then extended loads
    st(32'h13, 32'h000000F0, 2'd0, 0);
    ld(32'h13, 3'd0, 32'hFFFFFFF0, 0);
    ld(32'h13, 3'd3, 32'h000000F0, 0);
    ld(32'h10, 3'd2, 32'hF0ADBEEF, 0);
    ld(32'h12, 3'd1, 32'hFFFFF0AD, 0);
    ld(32'h12, 3'd4, 32'h0000F0AD, 0);

    // split word store and load
    st(32'h20, 32'h0, 2'd2, 0);
    st(32'h24, 32'h0, 2'd2, 0);
    st(32'h22, 32'h11223344, 2'd2, 1);
    ld(32'h20, 3'd2, 32'h33440000, 0);
    ld(32'h24, 3'd2, 32'h00001122, 0);
    ld(32'h22, 3'd2, 32'h11223344, 1);

    // halfword crossing the last word wraps to word 0
    st(32'(4*DEPTH-1), 32'h00000080, 2'd0, 0);
    st(32'h0, 32'h0000007F, 2'd0, 0);
    ld(32'(4*DEPTH-1), 3'd1, 32'h00007F80, 1);

    // illegal requests drop with an error pulse and leave RAM alone
    bad(1'b1, 1'b1, 32'h10, 3'd2, 2'd2);
    bad(1'b1, 1'b0, 32'h10, 3'd5, 2'd3);
    bad(1'b0, 1'b1, 32'h10, 3'd5, 2'd3);
    ld(32'h10, 3'd2, 32'hF0ADBEEF, 0);

    // reset during the second half of a split store
    st(32'h30, 32'h0, 2'd2, 0);
    st(32'h34, 32'hCAFEF00D, 2'd2, 0);
    bus.i_mem_wren   = 1'b1;
    bus.i_addr       = 32'h32;
    bus.i_st_data    = 32'hAABBCCDD;
    bus.i_st_rewrite = 2'd2;
    @(negedge i_clk);
    check("split_stall", 32'(bus.o_stall), 32'd1);
    @(posedge i_clk);
    #1;
    check("in_second", 32'(bus.dbg_state), 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    idle_inputs();
    #1;
    check("abort_state", 32'(bus.dbg_state), 32'd0);
    check("abort_ld_vld", 32'(bus.o_ld_vld), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    ld(32'h34, 3'd2, 32'hCAFEF00D, 0);
    ld(32'h30, 3'd2, 32'hCCDD0000, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
    @(negedge i_clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
